start_detect: RTL
=================

# start_detect

Parametrised, sequential start-bit validator for the UART receive path, replacing the combinational start check. It watches the serial line for a falling edge, majority-votes an odd number of oversampled points around the start-bit centre, and then flags the start as valid or as a glitch. It sits between the RX pin and the receive FSM, and keeps a saturating glitch count for diagnostics.

## Interface
- PRESC_W, 6: width of the runtime `prescale` input (oversampling clocks per bit).
- SAMPLES, 3: number of vote samples; must be odd (1, 3 or 5).
- GCNT_W, 8: width of the glitch counter.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- rx_in  input  1  serial line; idles high.
- en  input  1  detection enable; driven by the receive FSM, low during a frame.
- prescale  input  PRESC_W  clocks per bit; legal values are ≥ SAMPLES+3.
- clr_count  input  1  synchronous clear of `glitch_count`.
- busy  output  1  high while in CHECK.
- start_valid  output  1  one-cycle pulse: start bit confirmed.
- start_glitch  output  1  one-cycle pulse: start bit rejected.
- glitch_count  output  GCNT_W  saturating count of rejected starts.

## Operation
- rx_s is the line as seen by the FSM: synchronised `rx_in` (see Configuration). rx_prev is rx_s registered.
- States: IDLE, CHECK.
- IDLE:
  - An edge is `en && rx_prev==1 && rx_s==0`; the cycle it occurs is T0.
  - On an edge, latch `prescale` into p_reg, clear edge_cnt and zero_cnt, and go to CHECK.
  - A line held low never retriggers.
- CHECK:
  - edge_cnt increments every cycle from 0 (at T0+1).
  - mid = p_reg>>1; h = SAMPLES>>1.
  - When edge_cnt is in [mid-h, mid+h], zero_cnt increments if rx_s==0.
  - When edge_cnt == mid+h+1, the verdict is made:
    - zero_cnt > h: pulse `start_valid`.
    - Otherwise: pulse `start_glitch` and increment `glitch_count`.
  - After the verdict, return to IDLE.
- `en` dropping during CHECK aborts to IDLE with no pulse and no count change.
- `prescale` changes after T0 are ignored until the next edge.
- `glitch_count` saturates at all-ones.
- `clr_count` wins over a simultaneous glitch increment; the result is 0.
- `start_valid` and `start_glitch` are mutually exclusive, registered outputs.
- Counter widths: edge_cnt is PRESC_W bits; zero_cnt is $clog2(SAMPLES+1) bits. No wrap is possible for legal prescale.

## Timing
- Reset values:
  - state = IDLE.
  - rx_prev = 1; synchroniser flops = 1.
  - busy, start_valid, start_glitch = 0.
  - glitch_count = 0.
- Latency T0 → verdict pulse: mid + h + 2 cycles. With prescale=8, SAMPLES=3 this is T0+7.
- busy rises at T0+1 and falls in the verdict cycle.
- A new edge may be detected on the cycle after the verdict.
- Reset asserted mid-CHECK returns to IDLE on the next clk, with no pulse.
- Illegal prescale (< SAMPLES+3): behaviour is undefined; the bench must not drive it.

## Configuration
- START_DETECT_SYNC_EN defined:
  - rx_in passes through a 2-flop synchroniser reset to 1.
  - rx_s lags rx_in by 2 cycles.
- Not defined:
  - rx_s = rx_in directly, for inputs already synchronous to clk.
  - All edge-relative timing is unchanged; only the pin-to-T0 delay differs.

## Structure
- Package start_detect_pkg holds:
  - state enum (IDLE, CHECK);
  - default constants (DEF_PRESC_W=6, DEF_SAMPLES=3, DEF_GCNT_W=8);
  - MIN_PRESCALE function (SAMPLES+3).
- One sub-module, rx_sync: the 2-flop synchroniser, instantiated only under START_DETECT_SYNC_EN.
- Edge detect, FSM, vote and counter stay in start_detect.

## Test plan
- Reset/idle: rst_n low 2 cycles, rx_in=1, en=1 → all outputs 0, glitch_count=0, busy=0.
- Clean start: prescale=8, SAMPLES=3, rx low for 8 cycles → start_valid single pulse at T0+7, busy high T0+1..T0+7, glitch_count stays 0.
- Short glitch: rx low 2 cycles then high → start_glitch at T0+7, glitch_count=1. Repeat 255 more times with GCNT_W=8 → count stays 255; then clr_count coincident with a glitch → 0.
- Abort: edge, then en=0 at T0+3 → no pulse, busy low next cycle; a held-low line does not retrigger when en returns.
- Vote boundary: line low only at edge_cnt=3,4 (2 of 3 samples) → start_valid. Low only at edge_cnt=4 → start_glitch.
- Config: run the clean-start case with and without START_DETECT_SYNC_EN → pin-to-pulse delay differs by exactly 2 cycles.

Source files
------------

// File: rtl/start_detect_pkg.sv
// -----------------------------------------------------------------------------
// start_detect_pkg
//   Shared types and constants for the UART start-bit validator.
//   - state_e       : validator FSM states (IDLE, CHECK)
//   - DEF_*         : default parameter values for start_detect
//   - MIN_PRESCALE  : smallest legal runtime prescale for a given vote size
// -----------------------------------------------------------------------------
package start_detect_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam int DEF_PRESC_W = 6;
  localparam int DEF_SAMPLES = 3;
  localparam int DEF_GCNT_W  = 8;

  // The vote window (SAMPLES wide, centred on prescale/2) plus the verdict
  // cycle must fit inside one bit period.
  function automatic int MIN_PRESCALE(input int samples);
    return samples + 3;
  endfunction

endpackage

// File: rtl/start_detect_rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
//   Two-flop synchroniser for the asynchronous RX pin. Both flops reset to 1
//   so that the idle-high line produces no spurious falling edge after reset.
//   Ports:
//     clk   : system clock
//     rst_n : synchronous active-low reset
//     rx_i  : asynchronous serial input
//     rx_o  : rx_i delayed by two clk cycles, safe to use in the clk domain
// -----------------------------------------------------------------------------
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_o = sync_q;

endmodule

// File: rtl/start_detect.sv
// -----------------------------------------------------------------------------
// start_detect
//   Sequential start-bit validator for the UART receive path. Detects a
//   falling edge on the serial line, majority-votes SAMPLES oversampled points
//   centred on prescale/2 clocks after the edge, then pulses start_valid or
//   start_glitch. Rejected starts are counted in a saturating glitch counter.
//
//   Optional feature (compile-time macro START_DETECT_SYNC_EN):
//     defined   : rx_in passes through a 2-flop synchroniser (rx_sync)
//     undefined : rx_in is used directly (already synchronous to clk)
//
//   Ports:
//     clk          : system clock, rising edge
//     rst_n        : synchronous active-low reset
//     rx_in        : serial line, idles high
//     en           : detection enable from the receive FSM
//     prescale     : clocks per bit, latched at the detected edge
//     clr_count    : synchronous clear of glitch_count (wins over increment)
//     busy         : high while a start bit is being checked
//     start_valid  : one-cycle pulse, start bit confirmed
//     start_glitch : one-cycle pulse, start bit rejected
//     glitch_count : saturating count of rejected starts
// -----------------------------------------------------------------------------
module start_detect
  import start_detect_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int SAMPLES = DEF_SAMPLES,
  parameter int GCNT_W  = DEF_GCNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               clr_count,
  output logic               busy,
  output logic               start_valid,
  output logic               start_glitch,
  output logic [GCNT_W-1:0]  glitch_count
);

  localparam int                 ZC_W = $clog2(SAMPLES + 1);
  localparam int                 H    = SAMPLES / 2;
  localparam logic [PRESC_W-1:0] H_P  = PRESC_W'(H);
  localparam logic [ZC_W-1:0]    H_Z  = ZC_W'(H);

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic rx_s;

`ifdef START_DETECT_SYNC_EN
  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx_in),
    .rx_o  (rx_s)
  );
`else
  assign rx_s = rx_in;
`endif

  state_e             state_q;
  logic               rx_prev_q;
  logic               busy_q;
  logic               valid_q;
  logic               glitch_q;
  logic [PRESC_W-1:0] p_reg_q;
  logic [PRESC_W-1:0] edge_cnt_q;
  logic [ZC_W-1:0]    zero_cnt_q;
  logic [GCNT_W-1:0]  gcnt_q;

  logic [PRESC_W-1:0] mid;
  logic [PRESC_W-1:0] win_lo;
  logic [PRESC_W-1:0] win_hi;
  logic               edge_det;
  logic               in_window;
  logic               at_verdict;
  logic               verdict_done;
  logic               vote_ok;
  logic               glitch_inc;
  logic [ZC_W-1:0]    zero_cnt_d;
  logic [GCNT_W-1:0]  gcnt_d;

  always_comb begin
    edge_det     = en && rx_prev_q && !rx_s;
    mid          = p_reg_q >> 1;
    win_lo       = mid - H_P;
    win_hi       = mid + H_P;
    in_window    = (edge_cnt_q >= win_lo) && (edge_cnt_q <= win_hi);
    // Count includes the current sample so the verdict can be registered in
    // the same edge that takes the last vote sample.
    zero_cnt_d   = zero_cnt_q + ZC_W'(in_window && !rx_s);
    vote_ok      = zero_cnt_d > H_Z;
    at_verdict   = (state_q == CHECK) && en && (edge_cnt_q == win_hi);
    verdict_done = edge_cnt_q > win_hi;
    glitch_inc   = at_verdict && !vote_ok;
    if (clr_count) begin
      gcnt_d = '0;
    end else if (glitch_inc) begin
      gcnt_d = sat_inc(gcnt_q);
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  // The prescale snapshot is plain data: only meaningful once an edge has
  // loaded it, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && edge_det) begin
      p_reg_q <= prescale;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_prev_q  <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      glitch_q   <= 1'b0;
      edge_cnt_q <= '0;
      zero_cnt_q <= '0;
      gcnt_q     <= '0;
    end else begin
      rx_prev_q <= rx_s;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
      gcnt_q    <= gcnt_d;
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_q    <= CHECK;
            busy_q     <= 1'b1;
            edge_cnt_q <= '0;
            zero_cnt_q <= '0;
          end
        end
        CHECK: begin
          if (!en) begin
            // Frame handed to the receive FSM: drop the check silently.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            edge_cnt_q <= edge_cnt_q + 1'b1;
            zero_cnt_q <= zero_cnt_d;
            if (at_verdict) begin
              valid_q  <= vote_ok;
              glitch_q <= !vote_ok;
            end
            // Stay in CHECK through the cycle the pulse is visible, so the
            // earliest re-arm is the cycle after the verdict.
            if (verdict_done) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign start_valid  = valid_q;
  assign start_glitch = glitch_q;
  assign glitch_count = gcnt_q;

endmodule
